wb_buffer: RTL and testbench

- Writeback buffer between the execute/memory stages and the regfile write port.
- Queues register write requests (address, data) in a small FIFO and retires at most one per cycle into the regfile's we3/wa3/wd3 port.
- Forwards pending (not yet retired) data onto the regfile read outputs, so consumers see the youngest value for any register.
- Honours the XZR rule: register 31 always reads 0, and writes to it are discarded.

---
 rtl/wb_buffer.sv | 107 ++++++++++
 tb/tb_wb_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// Writeback buffer: queues register writes, retires one per cycle into the
// regfile write port, and forwards pending data onto the read outputs.
module wb_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_wa,
  input  logic [N-1:0]             in_wd,
  input  logic                     wb_stall,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [N-1:0]             wd3,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  input  logic [N-1:0]             rf_rd1,
  input  logic [N-1:0]             rf_rd2,
  output logic [N-1:0]             rd1,
  output logic [N-1:0]             rd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] XZR = 5'd31;

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [N-1:0]  data_q [DEPTH];
  logic [N-1:0]  data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] idx;
  logic          accept, store, retire;

  assign in_ready = (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // x31 writes complete the handshake but never occupy an entry
  assign store    = accept && (in_wa != XZR);
  assign retire   = (count_q != '0) && !wb_stall;

  assign we3   = retire;
  assign wa3   = (count_q != '0) ? addr_q[head_q] : '0;
  assign wd3   = (count_q != '0) ? data_q[head_q] : '0;
  assign count = count_q;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) begin
      addr_d[tail_q] = in_wa;
      data_d[tail_q] = in_wd;
      tail_d         = tail_q + PW'(1);
    end
    if (retire) begin
      head_d = head_q + PW'(1);
    end
    case ({store, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match wins; the head is included
  // even while it is being retired this cycle.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (addr_q[idx] == ra1) rd1 = data_q[idx];
        if (addr_q[idx] == ra2) rd2 = data_q[idx];
      end
    end
    if (ra1 == XZR) rd1 = '0;
    if (ra2 == XZR) rd2 = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: a queue-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_buffer;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready;
  logic [4:0]   in_wa;
  logic [N-1:0] in_wd;
  logic         wb_stall;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic [4:0]   ra1, ra2;
  logic [N-1:0] rf_rd1, rf_rd2, rd1, rd2;
  logic [2:0]   count;

  wb_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wa(in_wa), .in_wd(in_wd), .wb_stall(wb_stall), .we3(we3), .wa3(wa3),
    .wd3(wd3), .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1(rd1), .rd2(rd2), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   wa;
    logic [N-1:0] wd;
  } ent_t;

  ent_t         mq[$];
  logic [4:0]   ret_log[$];
  logic [N-1:0] rf[32];
  int           errors = 0;
  int           checks = 0;
  bit           m_acc, m_ret;

  assign rf_rd1 = rf[ra1];
  assign rf_rd2 = rf[ra2];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] fwd(input logic [4:0] ra, input logic [N-1:0] rfv);
    if (ra == 5'd31) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].wa == ra) return mq[i].wd;
    return rfv;
  endfunction

  // Regfile and model both advance on the clock edge
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 31; i++) rf[i] <= 64'h1000 + 64'(i);
      rf[31] <= 64'hDEAD;
    end else begin
      if (we3) begin
        rf[wa3] <= wd3;
        ret_log.push_back(wa3);
      end
      m_acc = in_valid && (mq.size() < DEPTH);
      m_ret = (mq.size() != 0) && !wb_stall;
      if (m_ret) void'(mq.pop_front());
      if (m_acc && in_wa != 5'd31) mq.push_back('{in_wa, in_wd});
    end
  end

  always @(negedge reset_n) mq.delete();

  always @(negedge clk) begin
    chk("count",    N'(count),    N'(mq.size()));
    chk("in_ready", N'(in_ready), N'(mq.size() < DEPTH));
    chk("we3",      N'(we3),      N'((mq.size() != 0) && !wb_stall));
    chk("wa3",      N'(wa3),      (mq.size() != 0) ? N'(mq[0].wa) : '0);
    chk("wd3",      wd3,          (mq.size() != 0) ? mq[0].wd : '0);
    chk("rd1",      rd1,          fwd(ra1, rf_rd1));
    chk("rd2",      rd2,          fwd(ra2, rf_rd2));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int j;
    int guard;
    reset_n = 1'b0; in_valid = 1'b0; in_wa = '0; in_wd = '0;
    wb_stall = 1'b0; ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    chk("rst_count", N'(count), 0);
    chk("rst_ready", N'(in_ready), 1);
    chk("rst_we3",   N'(we3), 0);
    chk("rst_wd3",   wd3, 0);
    chk("rst_rd1",   rd1, 64'h1005);
    chk("rst_rd2_x31", rd2, 0);

    // reset mid-queue
    in_valid = 1'b1; wb_stall = 1'b1; in_wa = 5'd2; in_wd = 64'd27;
    cyc();
    in_wa = 5'd3; in_wd = 64'd9;
    cyc();
    in_valid = 1'b0;
    #1 chk("mid_count_before", N'(count), 2);
    #1 reset_n = 1'b0;
    ra1 = 5'd2;
    #1;
    chk("mid_count", N'(count), 0);
    chk("mid_we3",   N'(we3), 0);
    chk("mid_ready", N'(in_ready), 1);
    chk("mid_rd1",   rd1, 64'h1002);
    cyc();
    reset_n = 1'b1; wb_stall = 1'b0;

    // single write latency; no forwarding in acceptance cycle
    in_valid = 1'b1; in_wa = 5'd2; in_wd = 64'd27; ra1 = 5'd2;
    #1 chk("lat_nofwd", rd1, 64'h1002);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("lat_we3", N'(we3), 1);
    chk("lat_wa3", N'(wa3), 2);
    chk("lat_wd3", wd3, 27);
    chk("lat_fwd_head", rd1, 27);
    cyc();
    #1;
    chk("lat_count", N'(count), 0);
    chk("lat_rf2",   rf[2], 27);
    chk("lat_rd1",   rd1, 27);

    // forwarding priority under stall
    wb_stall = 1'b1; in_valid = 1'b1;
    in_wa = 5'd5; in_wd = 64'd10; cyc();
    in_wa = 5'd5; in_wd = 64'd20; cyc();
    in_wa = 5'd6; in_wd = 64'd7;  cyc();
    in_valid = 1'b0; ra1 = 5'd5; ra2 = 5'd6;
    #1;
    chk("fwd_rd1_young", rd1, 20);
    chk("fwd_rd2",       rd2, 7);
    chk("fwd_count",     N'(count), 3);
    ra1 = 5'd4;
    #1 chk("fwd_rd1_miss", rd1, 64'h1004);
    repeat (3) cyc();
    wb_stall = 1'b0;
    repeat (3) cyc();
    #1;
    chk("fwd_drain", N'(count), 0);
    chk("fwd_rf5",   rf[5], 20);
    chk("fwd_rf6",   rf[6], 7);

    // XZR
    in_valid = 1'b1; in_wa = 5'd31; in_wd = 64'd52; ra2 = 5'd31;
    #1 chk("xzr_ready", N'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("xzr_count", N'(count), 0);
    chk("xzr_we3",   N'(we3), 0);
    chk("xzr_rd2",   rd2, 0);
    cyc();
    #1 chk("xzr_we3_later", N'(we3), 0);

    // full and wrap
    ret_log.delete();
    wb_stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_wa = 5'(10 + i); in_wd = 64'(100 + i);
      cyc();
    end
    in_wa = 5'd14; in_wd = 64'd104;
    #1;
    chk("full_count", N'(count), 4);
    chk("full_ready", N'(in_ready), 0);
    cyc(); cyc();
    #1 chk("full_hold", N'(count), 4);
    wb_stall = 1'b0;
    j = 4; guard = 0;
    while (j < 10 && guard < 100) begin
      acc = in_ready;
      cyc();
      guard++;
      if (acc) begin
        j++;
        if (j < 10) begin
          in_wa = 5'(10 + j); in_wd = 64'(100 + j);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("stream_done", N'(j), 10);
    guard = 0;
    while (count != 0 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("drain_done", N'(count), 0);
    chk("ret_len", N'(ret_log.size()), 10);
    for (int i = 0; i < 10 && i < ret_log.size(); i++)
      chk("ret_order", N'(ret_log[i]), N'(10 + i));
    chk("wrap_rf19", rf[19], 64'd109);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
